// File: rtl/niski_display_pkg.sv
// Shared display definitions: segment vector type and hex-to-segment table.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package niski_display_pkg;

    typedef logic [6:0] seg_t;

    // Standard hex font; b and d are lowercase so they differ from 8 and 0.
    localparam seg_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational hex nibble to 7-segment decoder (active-high {g..a}).
// Ports: nibble in [3:0], seg out [6:0].
module sevseg_decoder
    import niski_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevseg_mux.sv
// Multiplexed 7-segment display driver with brightness, dead time, LZS.
// Ports: clk, rst_n, enable, load, value, dp, blank, lzs, brightness in;
// segments, dp_out, select, frame_done out.
module sevseg_mux
    import niski_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 1,
    parameter int BRIGHT_BITS    = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dp,
    input  logic [DIGITS-1:0]      blank,
    input  logic                   lzs,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [6:0]             segments,
    output logic                   dp_out,
    output logic [DIGITS-1:0]      select,
    output logic                   frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Product of (brightness+1) and the slot span never overflows this.
    localparam int MW = BRIGHT_BITS + CW + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [MW-1:0] DEAD_W   = MW'(DEAD_CYCLES);
    localparam logic [MW-1:0] SPAN_W   = MW'(REFRESH_DIV - DEAD_CYCLES);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]      pend_blank_q, pend_blank_d;
    logic [DIGITS-1:0]      act_blank_q, act_blank_d;
    logic                   pend_lzs_q, pend_lzs_d, act_lzs_q, act_lzs_d;
    logic [BRIGHT_BITS-1:0] pend_br_q, pend_br_d, act_br_q, act_br_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [DIGITS-1:0]      sel_q, sel_d;

    logic                   wrap, last, frame_evt, xfer;
    logic [DIGITS-1:0]      zero_above, supp;
    logic [3:0]             cur_nib;
    logic [6:0]             dec_seg;
    logic [MW-1:0]          prod, on_end, cnt_w;
    logic                   slot_on;

    sevseg_decoder u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        last      = (idx_q == IDX_LAST);
        frame_evt = enable & wrap & last;
        // While idle, loads show up at once; while scanning, only at frame end.
        xfer      = frame_evt | ~enable;

        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            idx_d = idx_q;
            if (wrap) begin
                idx_d = last ? '0 : idx_q + 1'b1;
            end
        end

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_lzs_d   = pend_lzs_q;
        pend_br_d    = pend_br_q;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_lzs_d   = lzs;
            pend_br_d    = brightness;
        end

        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_lzs_d   = act_lzs_q;
        act_br_d    = act_br_q;
        if (xfer) begin
            act_val_d   = load ? value      : pend_val_q;
            act_dp_d    = load ? dp         : pend_dp_q;
            act_blank_d = load ? blank      : pend_blank_q;
            act_lzs_d   = load ? lzs        : pend_lzs_q;
            act_br_d    = load ? brightness : pend_br_q;
        end
    end

    // Prefix scan from the MSB: digit i is zero-led if it and all above are 0.
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS-1] = (act_val_q[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] & (act_val_q[4*i +: 4] == 4'h0);
        end
        supp = zero_above & {DIGITS{act_lzs_q}};
        supp[0] = 1'b0;
    end

    always_comb begin
        cur_nib = act_val_q[{idx_q, 2'b00} +: 4];
        prod    = (MW'(act_br_q) + MW'(1)) * SPAN_W;
        on_end  = DEAD_W + (prod >> BRIGHT_BITS);
        cnt_w   = MW'(cnt_q);
        slot_on = (cnt_w >= DEAD_W) && (cnt_w < on_end);

        seg_d = dec_seg;
        dp_d  = act_dp_q[idx_q];
        sel_d = '0;
        if (act_blank_q[idx_q]) begin
            seg_d = '0;
            dp_d  = 1'b0;
        end else begin
            if (supp[idx_q]) begin
                seg_d = '0;
            end
            if (enable && slot_on) begin
                sel_d[idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_lzs_q   <= 1'b0;
            pend_br_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            act_lzs_q    <= 1'b0;
            act_br_q     <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            sel_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_lzs_q   <= pend_lzs_d;
            pend_br_q    <= pend_br_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lzs_q    <= act_lzs_d;
            act_br_q     <= act_br_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
        end
    end

    // Gated by rst_n so a reset landing on the last cycle gives no pulse.
    assign frame_done = frame_evt & rst_n;
    assign segments   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp_out     = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign select     = SEL_ACTIVE_LOW ? ~sel_q : sel_q;

endmodule

// File: tb/tb_sevseg_mux.sv
// Self-checking bench for sevseg_mux: directed scenarios plus random run.
// Reference model tracks scan position as elapsed cycles since start.
module tb_sevseg_mux;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 1;
    localparam int BB = 3;
    localparam int FRAME = RD * ND;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic          lzs;
    logic [2:0]    brightness;
    logic [6:0]    segments;
    logic          dp_out;
    logic [3:0]    select;
    logic          frame_done;

    sevseg_mux #(
        .DIGITS         (ND),
        .REFRESH_DIV    (RD),
        .DEAD_CYCLES    (DC),
        .BRIGHT_BITS    (BB),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lzs        (lzs),
        .brightness (brightness),
        .segments   (segments),
        .dp_out     (dp_out),
        .select     (select),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    // Segment letters lit for each hex digit.
    string hex_str [16] = '{
        "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
        "aefg"
    };

    function automatic logic [6:0] font(input int n);
        string s;
        logic [6:0] r;
        s = hex_str[n];
        r = '0;
        for (int k = 0; k < s.len(); k++) begin
            r[int'(s[k]) - 97] = 1'b1;
        end
        return r;
    endfunction

    // Model state: elapsed scan cycles, pending and active settings.
    int          t;
    logic [15:0] p_val, a_val;
    logic [3:0]  p_dp, a_dp, p_bl, a_bl;
    logic        p_lzs, a_lzs;
    logic [2:0]  p_br, a_br;

    logic [6:0]  obs_seg;
    logic        obs_dp;
    logic [3:0]  obs_sel;
    logic        obs_fd;

    function automatic logic model_fd();
        return rst_n && enable && (t % RD == RD - 1) &&
               ((t / RD) % ND == ND - 1);
    endfunction

    task automatic model_out(output logic [6:0] es, output logic ed,
                             output logic [3:0] esel);
        int pre, dig, on_end;
        bit sup;
        es = '0;
        ed = 1'b0;
        esel = '0;
        if (rst_n) begin
            pre = t % RD;
            dig = (t / RD) % ND;
            on_end = DC + ((int'(a_br) + 1) * (RD - DC)) / (1 << BB);
            sup = a_lzs && dig > 0 && ((a_val >> (4 * dig)) == 16'h0);
            if (!a_bl[dig]) begin
                es = sup ? 7'h00 : font(int'((a_val >> (4 * dig)) & 16'hF));
                ed = a_dp[dig];
                if (enable && pre >= DC && pre < on_end) begin
                    esel[dig] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_tick();
        bit fe;
        if (!rst_n) begin
            t = 0;
            {p_val, p_dp, p_bl, p_lzs, p_br} = '0;
            {a_val, a_dp, a_bl, a_lzs, a_br} = '0;
        end else begin
            fe = model_fd();
            if (fe || !enable) begin
                if (load) {a_val, a_dp, a_bl, a_lzs, a_br} =
                    {value, dp, blank, lzs, brightness};
                else {a_val, a_dp, a_bl, a_lzs, a_br} =
                    {p_val, p_dp, p_bl, p_lzs, p_br};
            end
            if (load) {p_val, p_dp, p_bl, p_lzs, p_br} =
                {value, dp, blank, lzs, brightness};
            t = enable ? (t + 1) % FRAME : 0;
        end
    endtask

    task automatic step();
        logic [6:0] es, pin_s;
        logic ed, pin_d;
        logic [3:0] esel, pin_sel;
        model_out(es, ed, esel);
        model_tick();
        pin_s = ~es;
        pin_d = ~ed;
        pin_sel = ~esel;
        @(posedge clk);
        @(negedge clk);
        obs_seg = segments;
        obs_dp = dp_out;
        obs_sel = select;
        obs_fd = frame_done;
        chk("segments", 32'(obs_seg), 32'(pin_s));
        chk("dp_out", 32'(obs_dp), 32'(pin_d));
        chk("select", 32'(obs_sel), 32'(pin_sel));
        chk("frame_done", 32'(obs_fd), 32'(model_fd()));
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] b, input logic z,
                            input logic [2:0] br);
        value = v;
        dp = d;
        blank = b;
        lzs = z;
        brightness = br;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic idle_load(input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] b, input logic z,
                             input logic [2:0] br);
        enable = 1'b0;
        load_now(v, d, b, z, br);
        enable = 1'b1;
    endtask

    initial begin
        int cnt, last_fd, n;
        rst_n = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        value = '0;
        dp = '0;
        blank = '0;
        lzs = 1'b0;
        brightness = '0;
        t = 0;
        {p_val, p_dp, p_bl, p_lzs, p_br} = '0;
        {a_val, a_dp, a_bl, a_lzs, a_br} = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_sel", 32'(select), 32'h0F);
        chk("rst_seg", 32'(segments), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Scenario 1: 1234 at full brightness.
        idle_load(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
        cnt = 0;
        last_fd = -1;
        for (int k = 0; k < 70; k++) begin
            step();
            if (k < FRAME && obs_sel == 4'b1110) cnt++;
            if (obs_fd) begin
                if (last_fd >= 0) chk("fd_period", k - last_fd, FRAME);
                last_fd = k;
            end
        end
        chk("s1_slot0_on", cnt, 7);
        chk("s1_fd_seen", 32'(last_fd >= 0), 32'h1);

        // Scenario 2: dimmest gives no on-time, level 3 gives 3 per slot.
        idle_load(16'h1234, 4'h0, 4'h0, 1'b0, 3'd0);
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (obs_sel != 4'hF) cnt++;
        end
        chk("s2_br0_on", cnt, 0);
        idle_load(16'h1234, 4'h0, 4'h0, 1'b0, 3'd3);
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (obs_sel != 4'hF) cnt++;
        end
        chk("s2_br3_on", cnt, 12);

        // Scenario 3: leading-zero suppression.
        idle_load(16'h0070, 4'b1000, 4'h0, 1'b1, 3'd7);
        cnt = 0;
        n = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (obs_sel == 4'b1011 && obs_seg != 7'h7F) cnt++;
            if (obs_sel == 4'b0111 && obs_seg == 7'h7F && !obs_dp) n++;
        end
        chk("s3_d2_off", cnt, 0);
        chk("s3_d3_dp_only", n, 7);
        idle_load(16'h0000, 4'h0, 4'h0, 1'b1, 3'd7);
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (obs_sel != 4'hF && obs_sel != 4'b1110 && obs_seg != 7'h7F)
                cnt++;
        end
        chk("s3_zero_only_d0", cnt, 0);

        // Scenario 4: frame-aligned load, then a mid-frame load.
        value = 16'h0;
        lzs = 1'b0;
        n = 0;
        while (!obs_fd && n < 100) begin
            step();
            n++;
        end
        chk("s4_fd_timeout", 32'(obs_fd), 32'h1);
        load_now(16'hAAAA, 4'h0, 4'h0, 1'b0, 3'd7);
        for (int k = 0; k < 12; k++) step();
        load_now(16'h5555, 4'h0, 4'h0, 1'b0, 3'd7);
        for (int k = 0; k < 40; k++) step();

        // Scenario 5: blank digit 2.
        idle_load(16'h9876, 4'h0, 4'b0100, 1'b0, 3'd7);
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (obs_sel == 4'b1011) cnt++;
        end
        chk("s5_blank_sel", cnt, 0);

        // Scenario 6: enable dropped mid-frame.
        for (int k = 0; k < 10; k++) step();
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs_sel != 4'hF || obs_fd) cnt++;
        end
        chk("s6_idle", cnt, 0);
        enable = 1'b1;
        step();
        step();
        chk("s6_resume", 32'(obs_sel), 32'b1110);

        // Scenario 7: reset at prescaler 5 of digit 2.
        n = 0;
        while (t != 2 * RD + 5 && n < 100) begin
            step();
            n++;
        end
        chk("s7_pos_timeout", 32'(t), 32'(2 * RD + 5));
        rst_n = 1'b0;
        step();
        chk("s7_sel", 32'(obs_sel), 32'hF);
        chk("s7_seg", 32'(obs_seg), 32'h7F);
        chk("s7_dp", 32'(obs_dp), 32'h1);
        chk("s7_fd", 32'(obs_fd), 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk("s7_digit0", 32'(obs_seg), 32'h40);

        // Random run against the model.
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom % 200) != 0;
            if ($urandom % 60 == 0) enable = ~enable;
            load = ($urandom % 8) == 0;
            value = 16'($urandom) >> ($urandom % 16);
            dp = 4'($urandom);
            blank = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
            lzs = 1'($urandom);
            brightness = 3'($urandom);
            step();
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
